uc_arbiter: RTL and testbench

- Unit Clause Arbiter (uca): collects unit-clause literals produced by NUM_ENG process engines.
- Grants one engine per cycle, round-robin, and filters each granted literal against a variable-assignment table.
- New literals are broadcast-pushed into every engine's unit clause queue. Duplicates are dropped. A contradictory literal raises a sticky conflict and halts propagation until the next clear.

---
 rtl/uc_pkg.sv | 42 ++++
 rtl/rr_arbiter.sv | 56 +++++
 rtl/uc_arbiter.sv | 111 +++++++++++
 tb/tb_uc_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// Shared types for the unit clause arbiter: literal layout, FSM states and
// the classification of a granted literal against the assignment table.
package uc_pkg;

    localparam int unsigned UC_LENGTH = 512;
    localparam int unsigned LIT_W     = $clog2(UC_LENGTH);
    localparam int unsigned VAR_W     = LIT_W - 1;
    localparam int unsigned NUM_VAR   = 1 << VAR_W;

    // Polarity in the MSB (1 = negated), variable index below it.
    typedef struct packed {
        logic             neg;
        logic [VAR_W-1:0] var_idx;
    } lit_t;

    typedef enum logic {
        UCA_RUN,
        UCA_CONFLICT
    } uca_state_e;

    typedef enum logic [1:0] {
        UC_NEW,
        UC_DUP,
        UC_CONF
    } uc_class_e;

    // A positive literal assigns the variable to 1, a negated one to 0.
    function automatic uc_class_e classify(input logic assigned,
                                           input logic value,
                                           input lit_t lit);
        uc_class_e cls;
        if (!assigned) begin
            cls = UC_NEW;
        end else if (value == ~lit.neg) begin
            cls = UC_DUP;
        end else begin
            cls = UC_CONF;
        end
        return cls;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester selection: first request at or after the pointer,
// wrapping; the pointer moves past the winner only when the grant is taken.
module rr_arbiter #(
    parameter int unsigned N = 4,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic [N-1:0]     req_i,
    input  logic             adv_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             vld_o
);

    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] rr_ptr_d;

    always_comb begin
        int unsigned pos;
        pos   = 0;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        for (int unsigned off = 0; off < N; off++) begin
            pos = 32'(rr_ptr_q) + off;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!vld_o && req_i[IDX_W'(pos)]) begin
                vld_o = 1'b1;
                idx_o = IDX_W'(pos);
            end
        end
        if (vld_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (adv_i) begin
            rr_ptr_d = (idx_o == IDX_W'(N - 1)) ? '0 : idx_o + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/uc_arbiter.sv
// Unit clause arbiter: grants one engine literal per cycle, filters it
// against the variable assignment table and broadcasts new literals.
module uc_arbiter
    import uc_pkg::*;
#(
    parameter int unsigned NUM_ENG = 4,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic [NUM_ENG-1:0]       eng_valid_i,
    input  logic [NUM_ENG*LIT_W-1:0] eng_lit_i,
    output logic [NUM_ENG-1:0]       eng_ready_o,
    input  logic [NUM_ENG-1:0]       ucq_full_i,
    output logic                     ucq_push_o,
    output logic [LIT_W-1:0]         ucq_lit_o,
    output logic                     conflict_o,
    output logic [LIT_W-1:0]         conflict_lit_o,
    output logic [CNT_W-1:0]         push_cnt_o
);

    localparam int unsigned IDX_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

    uca_state_e         state_q;
    logic               conflict_q;
    lit_t               conflict_lit_q;
    logic [CNT_W-1:0]   push_cnt_q;
    logic [CNT_W-1:0]   push_cnt_d;
    logic [NUM_VAR-1:0] asg_q;
    logic [NUM_VAR-1:0] asg_d;
    logic [NUM_VAR-1:0] val_q;
    logic [NUM_VAR-1:0] val_d;

    logic [NUM_ENG-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_vld;
    lit_t               cand_lit;
    uc_class_e          cand_cls;
    logic               grant;
    logic               push;

    rr_arbiter #(
        .N (NUM_ENG)
    ) u_rr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clear_i),
        .req_i (eng_valid_i),
        .adv_i (grant),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

    // Classify the candidate; clear and reset suppress any grant this cycle.
    always_comb begin
        cand_lit = eng_lit_i[32'(arb_idx)*LIT_W +: LIT_W];
        cand_cls = classify(asg_q[cand_lit.var_idx], val_q[cand_lit.var_idx], cand_lit);
        grant    = !rst && !clear_i && (state_q == UCA_RUN) && arb_vld &&
                   ((cand_cls != UC_NEW) || !(|ucq_full_i));
        push     = grant && (cand_cls == UC_NEW);
    end

    assign eng_ready_o    = grant ? arb_gnt : '0;
    assign ucq_push_o     = push;
    assign ucq_lit_o      = push ? cand_lit : '0;
    assign conflict_o     = conflict_q;
    assign conflict_lit_o = conflict_lit_q;
    assign push_cnt_o     = push_cnt_q;

    always_comb begin
        asg_d      = asg_q;
        val_d      = val_q;
        push_cnt_d = push_cnt_q;
        if (push) begin
            asg_d[cand_lit.var_idx] = 1'b1;
            val_d[cand_lit.var_idx] = ~cand_lit.neg;
            if (push_cnt_q != '1) begin
                push_cnt_d = push_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            state_q        <= UCA_RUN;
            conflict_q     <= 1'b0;
            conflict_lit_q <= '0;
            push_cnt_q     <= '0;
            asg_q          <= '0;
            val_q          <= '0;
        end else begin
            asg_q      <= asg_d;
            val_q      <= val_d;
            push_cnt_q <= push_cnt_d;
            case (state_q)
                UCA_RUN: begin
                    if (grant && (cand_cls == UC_CONF)) begin
                        state_q        <= UCA_CONFLICT;
                        conflict_q     <= 1'b1;
                        conflict_lit_q <= cand_lit;
                    end
                end
                UCA_CONFLICT: state_q <= UCA_CONFLICT;
                default:      state_q <= UCA_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_uc_arbiter.sv
// Scoreboard bench for uc_arbiter: a table/queue model predicts grants,
// pushes and register state; a negedge monitor pops and compares.
module tb_uc_arbiter;
    import uc_pkg::*;

    localparam int NE = 4;
    localparam int CW = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                clear_i;
    logic [NE-1:0]       eng_valid_i;
    logic [NE*LIT_W-1:0] eng_lit_i;
    logic [NE-1:0]       eng_ready_o;
    logic [NE-1:0]       ucq_full_i;
    logic                ucq_push_o;
    logic [LIT_W-1:0]    ucq_lit_o;
    logic                conflict_o;
    logic [LIT_W-1:0]    conflict_lit_o;
    logic [CW-1:0]       push_cnt_o;

    always #5 clk = ~clk;

    uc_arbiter #(.NUM_ENG(NE), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (clear_i),
        .eng_valid_i    (eng_valid_i),
        .eng_lit_i      (eng_lit_i),
        .eng_ready_o    (eng_ready_o),
        .ucq_full_i     (ucq_full_i),
        .ucq_push_o     (ucq_push_o),
        .ucq_lit_o      (ucq_lit_o),
        .conflict_o     (conflict_o),
        .conflict_lit_o (conflict_lit_o),
        .push_cnt_o     (push_cnt_o)
    );

    typedef struct { int cyc; int eng; logic [LIT_W-1:0] lit; } gexp_t;
    typedef struct { int cyc; logic [LIT_W-1:0] lit; } pexp_t;
    typedef struct { bit conf; logic [LIT_W-1:0] clit; int cnt; } rexp_t;

    gexp_t gq[$];
    pexp_t pq[$];
    rexp_t rq[$];

    // Engine-side request state and environment controls
    bit               pv[NE];
    logic [LIT_W-1:0] pl[NE];
    logic [NE-1:0]    full_r;
    bit               clr_r;
    bit               rst_r;
    int               cyc;
    bit               mon_en;
    int               n_total;
    int               n_pass;

    // Reference state: -1 unassigned, else value of the variable
    int               m_tab[NUM_VAR];
    int               m_rr;
    bit               m_conf;
    logic [LIT_W-1:0] m_clit;
    int               m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual 0x%0h required 0x%0h at cycle %0d", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name, input logic [31:0] act);
        n_total++;
        $display("FAIL %s: actual 0x%0h with nothing expected at cycle %0d", name, act, cyc);
    endtask

    task automatic model_reset();
        for (int v = 0; v < NUM_VAR; v++) m_tab[v] = -1;
        m_rr   = 0;
        m_conf = 1'b0;
        m_clit = '0;
        m_cnt  = 0;
    endtask

    task automatic model_eval(output int g);
        int cand;
        int v;
        int want;
        logic [LIT_W-1:0] lit;
        rexp_t r;
        gexp_t ge;
        pexp_t pe;
        g = -1;
        r.conf = m_conf; r.clit = m_clit; r.cnt = m_cnt;
        rq.push_back(r);
        if (rst_r || clr_r) begin
            model_reset();
        end else if (!m_conf) begin
            cand = -1;
            for (int k = 0; k < NE; k++) begin
                if (cand < 0 && pv[(m_rr + k) % NE]) cand = (m_rr + k) % NE;
            end
            if (cand >= 0) begin
                lit  = pl[cand];
                v    = int'(lit) % NUM_VAR;
                want = (int'(lit) >= NUM_VAR) ? 0 : 1;
                if (m_tab[v] < 0) begin
                    if (full_r == '0) begin
                        g = cand;
                        pe.cyc = cyc; pe.lit = lit;
                        pq.push_back(pe);
                        m_tab[v] = want;
                        if (m_cnt < (1 << CW) - 1) m_cnt++;
                    end
                end else if (m_tab[v] == want) begin
                    g = cand;
                end else begin
                    g = cand;
                    m_conf = 1'b1;
                    m_clit = lit;
                end
                if (g >= 0) begin
                    ge.cyc = cyc; ge.eng = g; ge.lit = lit;
                    gq.push_back(ge);
                    m_rr = (g + 1) % NE;
                end
            end
        end
    endtask

    // One clock: drive inputs just after the edge, predict, retire grants
    task automatic cycle();
        int g;
        @(posedge clk);
        #1;
        cyc++;
        rst        = rst_r;
        clear_i    = clr_r;
        ucq_full_i = full_r;
        for (int e = 0; e < NE; e++) begin
            eng_valid_i[e] = pv[e];
            eng_lit_i[e*LIT_W +: LIT_W] = pl[e];
        end
        model_eval(g);
        if (g >= 0) pv[g] = 1'b0;
        mon_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            rexp_t r;
            gexp_t ge;
            pexp_t pe;
            if (rq.size() == 0) begin
                fail_now("reg_expect_underflow", 32'(push_cnt_o));
            end else begin
                r = rq.pop_front();
                check("conflict", 32'(conflict_o), 32'(r.conf));
                check("conflict_lit", 32'(conflict_lit_o), 32'(r.clit));
                check("push_cnt", 32'(push_cnt_o), 32'(r.cnt));
            end
            if (eng_ready_o != '0 || (gq.size() > 0 && gq[0].cyc == cyc)) begin
                if (gq.size() == 0) begin
                    fail_now("unexpected_grant", 32'(eng_ready_o));
                end else begin
                    ge = gq.pop_front();
                    check("grant_vec", 32'(eng_ready_o), 32'(1) << ge.eng);
                    check("grant_cycle", 32'(cyc), 32'(ge.cyc));
                    check("ready_without_valid", 32'(eng_ready_o & ~eng_valid_i), 32'(0));
                end
            end
            if (ucq_push_o || (pq.size() > 0 && pq[0].cyc == cyc)) begin
                if (pq.size() == 0) begin
                    fail_now("unexpected_push", 32'(ucq_lit_o));
                end else begin
                    pe = pq.pop_front();
                    check("push_flag", 32'(ucq_push_o), 32'(1));
                    check("push_lit", 32'(ucq_lit_o), 32'(pe.lit));
                    check("push_cycle", 32'(cyc), 32'(pe.cyc));
                end
            end else begin
                check("lit_idle", 32'(ucq_lit_o), 32'(0));
            end
        end
    end

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst = 1'b1; clear_i = 1'b0; eng_valid_i = '0; eng_lit_i = '0; ucq_full_i = '0;
        for (int e = 0; e < NE; e++) begin pv[e] = 1'b0; pl[e] = '0; end
        full_r = '0; clr_r = 1'b0; rst_r = 1'b0; cyc = 0; mon_en = 1'b0;
        n_total = 0; n_pass = 0;
        model_reset();
        repeat (2) @(posedge clk);
        run(1);

        // Four distinct new literals held together: e0..e3 in order
        for (int e = 0; e < NE; e++) begin pv[e] = 1'b1; pl[e] = LIT_W'(e + 1); end
        run(5);
        check("cnt_after_four", 32'(push_cnt_o), 32'(4));

        // Same variable from two engines: e0 pushes, e1 is a duplicate
        pv[0] = 1'b1; pl[0] = LIT_W'(9'h007);
        pv[1] = 1'b1; pl[1] = LIT_W'(9'h007);
        run(3);
        check("cnt_after_same_var", 32'(push_cnt_o), 32'(5));

        pv[0] = 1'b1; pl[0] = LIT_W'(9'h005);
        run(2);
        check("cnt_after_005", 32'(push_cnt_o), 32'(6));

        // Duplicate then contradiction on variable 5
        pv[2] = 1'b1; pl[2] = LIT_W'(9'h005);
        run(1);
        pv[1] = 1'b1; pl[1] = LIT_W'(9'h105);
        run(2);
        check("conflict_set", 32'(conflict_o), 32'(1));
        check("conflict_lit_105", 32'(conflict_lit_o), 32'(9'h105));

        pv[0] = 1'b1; pl[0] = LIT_W'(9'h050);
        run(3);
        check("conflict_sticky", 32'(conflict_o), 32'(1));

        // Clear with a request pending: no grant that cycle, table emptied
        clr_r = 1'b1;
        run(1);
        clr_r = 1'b0;
        run(1);
        check("conflict_cleared", 32'(conflict_o), 32'(0));
        check("cnt_cleared", 32'(push_cnt_o), 32'(0));
        pv[1] = 1'b1; pl[1] = LIT_W'(9'h105);
        run(2);
        check("cnt_after_clear_pushes", 32'(push_cnt_o), 32'(2));

        // Full queue stalls a new literal but not a duplicate
        full_r = 4'b1000;
        pv[0] = 1'b1; pl[0] = LIT_W'(9'h00A);
        run(3);
        full_r = '0;
        run(1);
        full_r = 4'b1000;
        pv[3] = 1'b1; pl[3] = LIT_W'(9'h00A);
        run(1);
        full_r = '0;
        run(1);
        check("cnt_after_full", 32'(push_cnt_o), 32'(3));

        // Randomized traffic over a small variable set to provoke dups/conflicts
        for (int i = 0; i < 3000; i++) begin
            int vr;
            for (int e = 0; e < NE; e++) begin
                if (!pv[e] && $urandom_range(0, 1) == 1) begin
                    vr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, NUM_VAR - 1))
                                                     : int'($urandom_range(0, 15));
                    pv[e] = 1'b1;
                    pl[e] = LIT_W'(int'($urandom_range(0, 1)) * NUM_VAR + vr);
                end
            end
            full_r = ($urandom_range(0, 3) == 0) ? NE'($urandom) : '0;
            clr_r  = m_conf ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 99) == 0);
            rst_r  = ($urandom_range(0, 499) == 0);
            run(1);
        end

        for (int e = 0; e < NE; e++) pv[e] = 1'b0;
        full_r = '0; clr_r = 1'b0; rst_r = 1'b0;
        run(2);
        check("grant_queue_drained", 32'(gq.size()), 32'(0));
        check("push_queue_drained", 32'(pq.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
